// File: rtl/equiv_check_sequencer_if.sv
// Stimulus/compare bundle between the equivalence sequencer (master) and the DUT pair plus observer (slave).
interface equiv_check_sequencer_if #(
   parameter int IN_W   = 2,
   parameter int OUT_W  = 1,
   parameter int MCNT_W = 16
);
   logic              start;
   logic [IN_W-1:0]   stim;
   logic [OUT_W-1:0]  golden_out;
   logic [OUT_W-1:0]  netlist_out;
   logic              busy;
   logic              done;
   logic              pass;
   logic              mismatch_pulse;
   logic [MCNT_W-1:0] mismatch_count;
   logic [31:0]       vec_count;
   logic [31:0]       first_fail_vec;

   modport master (
      input  start, golden_out, netlist_out,
      output stim, busy, done, pass, mismatch_pulse, mismatch_count, vec_count, first_fail_vec
   );

   modport slave (
      output start, golden_out, netlist_out,
      input  stim, busy, done, pass, mismatch_pulse, mismatch_count, vec_count, first_fail_vec
   );
endinterface

// File: rtl/equiv_check_sequencer.sv
// Drives exhaustive then LFSR-random vectors into a golden/netlist pair and
// compares their outputs after a settle window; all outputs are registered.
module equiv_check_sequencer #(
   parameter int          IN_W          = 2,
   parameter int          OUT_W         = 1,
   parameter int          RAND_VECTORS  = 500,
   parameter int          SETTLE_CYCLES = 1,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1,
   parameter int          MCNT_W        = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   equiv_check_sequencer_if.master bus
);
   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_COMPARE, S_DONE} state_t;

   localparam int unsigned EXH   = 1 << IN_W;
   localparam logic [31:0] N_VEC = 32'(EXH) + 32'(RAND_VECTORS);
   localparam int          SC_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SC_W-1:0] SETTLE_LOAD = SC_W'(SETTLE_CYCLES - 1);

   // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
   endfunction

   state_t            state_q, state_d;
   logic [SC_W-1:0]   settle_q, settle_d;
   logic [15:0]       lfsr_q, lfsr_d;
   logic [IN_W-1:0]   stim_q, stim_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic              pulse_q, pulse_d;
   logic [MCNT_W-1:0] mcnt_q, mcnt_d;
   logic [31:0]       vec_q, vec_d;
   logic [31:0]       ffv_q, ffv_d;
   logic              mismatch;

   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      lfsr_d   = lfsr_q;
      stim_d   = stim_q;
      busy_d   = busy_q;
      done_d   = done_q;
      pass_d   = pass_q;
      pulse_d  = 1'b0;
      mcnt_d   = mcnt_q;
      vec_d    = vec_q;
      ffv_d    = ffv_q;
      mismatch = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               state_d  = S_SETTLE;
               settle_d = SETTLE_LOAD;
               lfsr_d   = LFSR_SEED;
               stim_d   = '0;
               busy_d   = 1'b1;
               done_d   = 1'b0;
               pass_d   = 1'b0;
               mcnt_d   = '0;
               vec_d    = '0;
               ffv_d    = '0;
            end
         end
         S_SETTLE: begin
            if (settle_q == '0) state_d = S_COMPARE;
            else                settle_d = settle_q - 1'b1;
         end
         S_COMPARE: begin
            // Case inequality so an X/Z on either side counts as a failure.
            mismatch = (bus.golden_out !== bus.netlist_out);
            vec_d    = vec_q + 32'd1;
            if (mismatch) begin
               pulse_d = 1'b1;
               if (mcnt_q != '1) mcnt_d = mcnt_q + 1'b1;
               if (mcnt_q == '0) ffv_d = vec_q;
            end
            if (vec_d < N_VEC) begin
               state_d  = S_SETTLE;
               settle_d = SETTLE_LOAD;
               if (vec_d < 32'(EXH)) begin
                  stim_d = vec_d[IN_W-1:0];
               end else begin
                  lfsr_d = lfsr_step(lfsr_q);
                  stim_d = lfsr_d[IN_W-1:0];
               end
            end else begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (mcnt_d == '0);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         settle_q <= '0;
         lfsr_q   <= LFSR_SEED;
         stim_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
         pulse_q  <= 1'b0;
         mcnt_q   <= '0;
         vec_q    <= '0;
         ffv_q    <= '0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         lfsr_q   <= lfsr_d;
         stim_q   <= stim_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         pass_q   <= pass_d;
         pulse_q  <= pulse_d;
         mcnt_q   <= mcnt_d;
         vec_q    <= vec_d;
         ffv_q    <= ffv_d;
      end
   end

   assign bus.stim           = stim_q;
   assign bus.busy           = busy_q;
   assign bus.done           = done_q;
   assign bus.pass           = pass_q;
   assign bus.mismatch_pulse = pulse_q;
   assign bus.mismatch_count = mcnt_q;
   assign bus.vec_count      = vec_q;
   assign bus.first_fail_vec = ffv_q;
endmodule

// File: tb/tb_equiv_check_sequencer.sv
// Directed bench: four sequencer configurations driving and2 golden/netlist pairs.
module tb_equiv_check_sequencer;
   logic clk;
   logic reset;
   logic [1:0] mode_b;
   logic x_val = 1'bx;
   int checks = 0;
   int errors = 0;

   equiv_check_sequencer_if #(.IN_W(2), .OUT_W(1), .MCNT_W(16)) bus_a ();
   equiv_check_sequencer_if #(.IN_W(2), .OUT_W(1), .MCNT_W(16)) bus_b ();
   equiv_check_sequencer_if #(.IN_W(2), .OUT_W(1), .MCNT_W(2))  bus_c ();
   equiv_check_sequencer_if #(.IN_W(2), .OUT_W(1), .MCNT_W(16)) bus_d ();

   equiv_check_sequencer #(.IN_W(2), .OUT_W(1), .RAND_VECTORS(4), .SETTLE_CYCLES(1),
      .LFSR_SEED(16'hACE1), .MCNT_W(16)) u_a (.clk(clk), .reset(reset), .bus(bus_a));
   equiv_check_sequencer #(.IN_W(2), .OUT_W(1), .RAND_VECTORS(0), .SETTLE_CYCLES(1),
      .LFSR_SEED(16'hACE1), .MCNT_W(16)) u_b (.clk(clk), .reset(reset), .bus(bus_b));
   equiv_check_sequencer #(.IN_W(2), .OUT_W(1), .RAND_VECTORS(40), .SETTLE_CYCLES(1),
      .LFSR_SEED(16'hACE1), .MCNT_W(2)) u_c (.clk(clk), .reset(reset), .bus(bus_c));
   equiv_check_sequencer #(.IN_W(2), .OUT_W(1), .RAND_VECTORS(0), .SETTLE_CYCLES(3),
      .LFSR_SEED(16'hACE1), .MCNT_W(16)) u_d (.clk(clk), .reset(reset), .bus(bus_d));

   // and2 golden models; netlist variants: identical, stuck-at-0, or X.
   assign bus_a.golden_out  = bus_a.stim[0] & bus_a.stim[1];
   assign bus_a.netlist_out = bus_a.stim[0] & bus_a.stim[1];
   assign bus_b.golden_out  = bus_b.stim[0] & bus_b.stim[1];
   assign bus_b.netlist_out = (mode_b == 2'd0) ? (bus_b.stim[0] & bus_b.stim[1]) :
                              (mode_b == 2'd1) ? 1'b0 : x_val;
   assign bus_c.golden_out  = bus_c.stim[0] & bus_c.stim[1];
   assign bus_c.netlist_out = 1'b0;
   assign bus_d.golden_out  = bus_d.stim[0] & bus_d.stim[1];
   assign bus_d.netlist_out = bus_d.stim[0] & bus_d.stim[1];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_zero_a(input string tag);
      check({tag, "_stim"},  32'(bus_a.stim), 32'd0);
      check({tag, "_busy"},  32'(bus_a.busy), 32'd0);
      check({tag, "_done"},  32'(bus_a.done), 32'd0);
      check({tag, "_pass"},  32'(bus_a.pass), 32'd0);
      check({tag, "_pulse"}, 32'(bus_a.mismatch_pulse), 32'd0);
      check({tag, "_mcnt"},  32'(bus_a.mismatch_count), 32'd0);
      check({tag, "_vec"},   bus_a.vec_count, 32'd0);
      check({tag, "_ffv"},   bus_a.first_fail_vec, 32'd0);
   endtask

   // Full run on instance A; LFSR from ACE1 gives random low bits 0,0,0,2.
   task automatic run_a(input string tag);
      int n;
      int pulses;
      logic [1:0] seen [8];
      logic [1:0] exp_seq [8];
      exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd2};
      for (int i = 0; i < 8; i++) seen[i] = 2'd0;
      @(negedge clk) bus_a.start = 1'b1;
      @(negedge clk) bus_a.start = 1'b0;
      n = 0;
      pulses = 0;
      seen[0] = bus_a.stim;
      check({tag, "_busy_on"}, 32'(bus_a.busy), 32'd1);
      while (!bus_a.done && n < 200) begin
         @(negedge clk);
         n++;
         if (bus_a.mismatch_pulse) pulses++;
         if (n % 2 == 0 && n < 16) seen[n/2] = bus_a.stim;
      end
      check({tag, "_latency"}, 32'(n), 32'd16);
      for (int i = 0; i < 8; i++)
         check($sformatf("%s_stim%0d", tag, i), 32'(seen[i]), 32'(exp_seq[i]));
      check({tag, "_vec"},    bus_a.vec_count, 32'd8);
      check({tag, "_mcnt"},   32'(bus_a.mismatch_count), 32'd0);
      check({tag, "_pass"},   32'(bus_a.pass), 32'd1);
      check({tag, "_busy"},   32'(bus_a.busy), 32'd0);
      check({tag, "_pulses"}, 32'(pulses), 32'd0);
   endtask

   task automatic run_b(input string tag, input int exp_cnt, input int exp_first);
      int n;
      int pulses;
      int pidx;
      @(negedge clk) bus_b.start = 1'b1;
      @(negedge clk) bus_b.start = 1'b0;
      n = 0;
      pulses = 0;
      pidx = -1;
      while (!bus_b.done && n < 100) begin
         @(negedge clk);
         n++;
         if (bus_b.mismatch_pulse) begin
            if (pulses == 0) pidx = int'(bus_b.vec_count) - 1;
            pulses++;
         end
      end
      check({tag, "_latency"}, 32'(n), 32'd8);
      check({tag, "_vec"},     bus_b.vec_count, 32'd4);
      check({tag, "_mcnt"},    32'(bus_b.mismatch_count), 32'(exp_cnt));
      check({tag, "_ffv"},     bus_b.first_fail_vec, 32'(exp_first));
      check({tag, "_pulses"},  32'(pulses), 32'(exp_cnt));
      if (exp_cnt > 0) check({tag, "_pulse_idx"}, 32'(pidx), 32'(exp_first));
      check({tag, "_pass"},    32'(bus_b.pass), 32'(exp_cnt == 0));
   endtask

   initial begin
      int n;
      int x_cnt;
      int x_first;
      int c_tot;
      logic [15:0] l;

      reset = 1'b1;
      mode_b = 2'd0;
      bus_a.start = 1'b0;
      bus_b.start = 1'b0;
      bus_c.start = 1'b0;
      bus_d.start = 1'b0;
      repeat (2) @(negedge clk);
      check_zero_a("rst");
      reset = 1'b0;

      // Scenario 1: clean run, then outputs held in DONE.
      run_a("s1");
      repeat (3) @(negedge clk);
      check("s1_hold_done", 32'(bus_a.done), 32'd1);
      check("s1_hold_stim", 32'(bus_a.stim), 32'd2);

      // Scenario 2: stuck-at-0 netlist fails only on stim=3.
      mode_b = 2'd1;
      run_b("s2", 1, 3);

      // Scenario 3: X netlist; expectations use case-inequality on the same value.
      mode_b = 2'd2;
      x_cnt = 0;
      x_first = 0;
      for (int i = 0; i < 4; i++) begin
         logic g;
         g = (i == 3);
         if (g !== x_val) begin
            if (x_cnt == 0) x_first = i;
            x_cnt++;
         end
      end
      run_b("s3", x_cnt, x_first);

      // Scenario 4: start ignored while busy, reset aborts, rerun matches scenario 1.
      @(negedge clk) bus_a.start = 1'b1;
      @(negedge clk) bus_a.start = 1'b0;
      repeat (3) @(negedge clk);
      bus_a.start = 1'b1;
      @(negedge clk) bus_a.start = 1'b0;
      repeat (2) @(negedge clk);
      check("s4_mid_vec",  bus_a.vec_count, 32'd3);
      check("s4_mid_stim", 32'(bus_a.stim), 32'd3);
      check("s4_mid_busy", 32'(bus_a.busy), 32'd1);
      reset = 1'b1;
      @(negedge clk) reset = 1'b0;
      check_zero_a("s4_rst");
      repeat (3) @(negedge clk);
      check("s4_idle_busy", 32'(bus_a.busy), 32'd0);
      run_a("s4_rerun");

      // Scenario 5: saturation of a 2-bit counter over 44 vectors.
      l = 16'hACE1;
      c_tot = 1;
      for (int i = 0; i < 40; i++) begin
         l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
         if (l[1:0] == 2'b11) c_tot++;
      end
      @(negedge clk) bus_c.start = 1'b1;
      @(negedge clk) bus_c.start = 1'b0;
      n = 0;
      while (!bus_c.done && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("s5_latency", 32'(n), 32'd88);
      check("s5_vec",     bus_c.vec_count, 32'd44);
      check("s5_mcnt",    32'(bus_c.mismatch_count), (c_tot >= 3) ? 32'd3 : 32'(c_tot));
      check("s5_ffv",     bus_c.first_fail_vec, 32'd3);
      check("s5_pass",    32'(bus_c.pass), 32'd0);

      // Scenario 6: longer settle window holds each vector for four cycles.
      @(negedge clk) bus_d.start = 1'b1;
      @(negedge clk) bus_d.start = 1'b0;
      n = 0;
      while (!bus_d.done && n < 200) begin
         @(negedge clk);
         n++;
         if (n == 3) check("s6_stim_hold", 32'(bus_d.stim), 32'd0);
         if (n == 4) check("s6_stim_next", 32'(bus_d.stim), 32'd1);
         if (n == 4) check("s6_vec_first", bus_d.vec_count, 32'd1);
      end
      check("s6_latency", 32'(n), 32'd16);
      check("s6_vec",     bus_d.vec_count, 32'd4);
      check("s6_pass",    32'(bus_d.pass), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
